mop_sequencer: RTL
==================

Name: mop_sequencer

Overview:
- Sits between the micro-op cracker and the issue/rename stage.
- Accepts one cracked instruction bundle per handshake: a count plus up to MAX_MOP_CNT micro-ops.
- Issues the micro-ops downstream one per cycle, in index order, over a valid/ready interface.
- Tags each micro-op with an instruction sequence number and first/last markers, and supports a pipeline flush.

Parameters:
MAX_MOP_CNT, 6, maximum micro-ops per instruction bundle
MOP_W, 128, width in bits of one packed micro-op
SEQ_W, 8, width of the instruction sequence counter
CNT_W, 3, width of count/index fields (must satisfy 2**CNT_W > MAX_MOP_CNT)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  cracker presents a bundle
in_ready  output  1  sequencer accepts bundle this cycle
in_cnt  input  CNT_W  number of valid micro-ops in bundle (0..MAX_MOP_CNT legal)
in_mops  input  MAX_MOP_CNT*MOP_W  micro-op array, entry i at bits [i*MOP_W +: MOP_W]
out_valid  output  1  micro-op presented downstream
out_ready  input  1  downstream accepts micro-op
out_mop  output  MOP_W  current micro-op
out_idx  output  CNT_W  index of out_mop within its bundle
out_first  output  1  out_idx == 0
out_last  output  1  out_idx == bundle count-1
out_seq  output  SEQ_W  sequence number of the bundle being issued
flush  input  1  synchronous discard of the in-flight bundle
busy  output  1  state == ISSUE
err_cnt  output  1  sticky: a bundle with in_cnt > MAX_MOP_CNT was received

Behaviour:
- Reset: asynchronous, active-low. State=IDLE; buffer, idx, cnt, seq and err_cnt clear to 0. out_valid=0, busy=0. in_ready=1 once reset_n deasserts.
- Storage: one bundle register (MAX_MOP_CNT x MOP_W), latched count, issue index, sequence counter.
- Handshakes: a transfer occurs when valid && ready. in_ready and out_ready are sampled on the rising clk edge.
- State IDLE:
  - out_valid=0; in_ready=!flush.
  - Accept with in_cnt==0: bundle retires immediately (nop). seq += 1; stay IDLE; nothing issued.
  - Accept with in_cnt > MAX_MOP_CNT: bundle dropped; err_cnt set to 1 (sticky until reset); seq unchanged; stay IDLE.
  - Accept with 1 <= in_cnt <= MAX_MOP_CNT: latch in_mops and in_cnt; idx=0; go ISSUE.
- State ISSUE:
  - out_valid=1; out_mop=buf[idx]; out_idx=idx; out_seq=seq.
  - out_first and out_last are decoded from the registered idx and cnt.
  - While out_valid && !out_ready, all outputs are held stable.
  - Transfer with !out_last: idx += 1.
  - Transfer with out_last: bundle retires and seq += 1 (wraps modulo 2**SEQ_W).
  - in_ready = out_ready && out_last && !flush (combinational). This gives back-to-back bundles with no bubble.
  - If a new bundle is accepted in the same cycle as the last transfer, apply the IDLE accept rules: legal count gives idx=0 and stay ISSUE; zero count gives seq += 2 total and go IDLE; illegal count sets err, seq += 1, go IDLE.
  - Last transfer with no new bundle: go IDLE.
- Throughput: an N-mop bundle occupies exactly N cycles with out_ready held high.
- Latency: first micro-op appears on out_* the cycle after in_* acceptance.
- flush (highest priority over all events):
  - Next state is IDLE; out_valid deasserts the following cycle; in_ready=0 during the flush cycle.
  - An out transfer in the flush cycle still counts as issued, but seq does not increment for a partially issued bundle.
  - err_cnt is unaffected.
- Reset mid-issue: outputs drop immediately (asynchronous); the bundle is lost.
- Width rules: idx and cnt are CNT_W unsigned. idx never exceeds cnt-1. seq wraps with no flag.

Test Plan:
1. Reset with out_ready=1: send bundle cnt=4, then cnt=2 held valid. Mops idx 0,1,2,3 with seq=0 on consecutive cycles; out_first only on idx0, out_last on idx3. Second bundle accepted in the idx3 cycle; its idx0 appears the next cycle with seq=1 and no bubble.
2. Backpressure: cnt=3; drop out_ready for 3 cycles while idx=1 is shown. out_mop/out_idx/out_seq stay unchanged and in_ready=0. idx2 follows one cycle after out_ready returns high.
3. Nop and error: cnt=0 gives in_ready=1, no out_valid, seq 0->1. Then cnt=7 gives err_cnt=1, no out_valid, seq stays 1. err_cnt stays 1 after further legal bundles.
4. Flush: cnt=6; assert flush while idx=2 is shown. out_valid=0 the next cycle, seq unchanged. A following cnt=1 bundle issues with idx=0, out_first=out_last=1.
5. Async reset: assert reset_n=0 mid-bundle (idx=1) off the clock edge. out_valid and busy fall immediately and seq=0. After release, the first bundle issues with seq=0.
6. Sequence wrap: drive 256 bundles of cnt=1 (SEQ_W=8). out_seq runs 0..255 then 0; there are no gaps between issued mops.

Source files
------------

// File: rtl/mop_sequencer.sv
// Micro-op sequencer: latches one cracked instruction bundle and issues its micro-ops
// downstream one per cycle, tagged with sequence number and first/last markers.
module mop_sequencer #(
  parameter int unsigned MAX_MOP_CNT = 6,
  parameter int unsigned MOP_W       = 128,
  parameter int unsigned SEQ_W       = 8,
  parameter int unsigned CNT_W       = 3
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CNT_W-1:0]             in_cnt,
  input  logic [MAX_MOP_CNT*MOP_W-1:0] in_mops,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [MOP_W-1:0]             out_mop,
  output logic [CNT_W-1:0]             out_idx,
  output logic                         out_first,
  output logic                         out_last,
  output logic [SEQ_W-1:0]             out_seq,
  input  logic                         flush,
  output logic                         busy,
  output logic                         err_cnt
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_MOP_CNT);

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e                                state_q, state_d;
  logic [MAX_MOP_CNT-1:0][MOP_W-1:0]     mop_buf_q, mop_buf_d;
  logic [CNT_W-1:0]                      cnt_q, cnt_d;
  logic [CNT_W-1:0]                      idx_q, idx_d;
  logic [SEQ_W-1:0]                      seq_q, seq_d;
  logic                                  err_q, err_d;

  logic in_xfer, out_xfer;

  always_comb begin
    out_valid = (state_q == StIssue);
    busy      = (state_q == StIssue);
    out_mop   = mop_buf_q[idx_q];
    out_idx   = idx_q;
    out_seq   = seq_q;
    out_first = (idx_q == '0);
    out_last  = (idx_q == cnt_q - CNT_W'(1));
    err_cnt   = err_q;
    // Accepting while the last micro-op leaves lets bundles stream without a bubble.
    if (state_q == StIdle) begin
      in_ready = !flush;
    end else begin
      in_ready = out_ready && out_last && !flush;
    end
    in_xfer  = in_valid && in_ready;
    out_xfer = out_valid && out_ready;
  end

  always_comb begin
    state_d   = state_q;
    mop_buf_d = mop_buf_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    seq_d     = seq_q;
    err_d     = err_q;

    if (out_xfer) begin
      if (out_last) begin
        seq_d   = seq_q + SEQ_W'(1);
        state_d = StIdle;
      end else begin
        idx_d = idx_q + CNT_W'(1);
      end
    end

    // A flushed partial bundle is dropped without consuming a sequence number.
    if (flush) begin
      state_d = StIdle;
    end else if (in_xfer) begin
      if (in_cnt == '0) begin
        seq_d = seq_d + SEQ_W'(1);
      end else if (in_cnt > MaxCnt) begin
        err_d = 1'b1;
      end else begin
        mop_buf_d = in_mops;
        cnt_d     = in_cnt;
        idx_d     = '0;
        state_d   = StIssue;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      mop_buf_q <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      seq_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mop_buf_q <= mop_buf_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      seq_q     <= seq_d;
      err_q     <= err_d;
    end
  end

endmodule
